// File: rtl/noise_filter_ctrl.sv
// rtl/noise_filter_ctrl.sv - sequences one moving-average noise filter for a single sample stream
module noise_filter_ctrl #(
    parameter int DATA_WIDTH = 24,
    parameter int N          = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  bypass,
    output logic                  flt_write,
    output logic [DATA_WIDTH-1:0] flt_data,
    input  logic                  flt_done,
    input  logic [DATA_WIDTH-1:0] flt_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  warm,
    output logic                  err
);
    localparam int                WAIT_W    = $clog2(TIMEOUT);
    localparam logic [N:0]        WARM_FULL = {1'b1, {N{1'b0}}};
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t                  state;
    logic                    hold_full;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic [DATA_WIDTH-1:0]   work_data;
    logic [N:0]              warm_cnt;
    logic [WAIT_W-1:0]       wait_cnt;

    assign in_ready = !reset && !hold_full;
    assign warm     = (warm_cnt == WARM_FULL);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold_full <= 1'b0;
            hold_data <= '0;
            work_data <= '0;
            warm_cnt  <= '0;
            wait_cnt  <= '0;
            flt_write <= 1'b0;
            flt_data  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            flt_write <= 1'b0;
            err       <= 1'b0;

            // The holding register fills in any state so one sample queues behind the one in flight.
            if (in_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= in_data;
            end

            case (state)
                ST_IDLE: begin
                    if (hold_full) begin
                        hold_full <= 1'b0;
                        work_data <= hold_data;
                        if (bypass) begin
                            out_data  <= hold_data;
                            out_valid <= 1'b1;
                            state     <= ST_OUT;
                        end else begin
                            flt_data  <= hold_data;
                            flt_write <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (flt_done) begin
                        // Until the window is full the filter sum is not meaningful; pass raw.
                        out_data  <= warm ? flt_sum : work_data;
                        out_valid <= 1'b1;
                        if (!warm) begin
                            warm_cnt <= warm_cnt + 1'b1;
                        end
                        state <= ST_OUT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err       <= 1'b1;
                        warm_cnt  <= '0;
                        hold_full <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
